fetch: RTL and testbench
========================

# fetch

Instruction fetch stage directly upstream of `decode`: owns the architectural fetch PC, issues word requests to the instruction cache, and looks up the branch predictor. Fetched words go into an in-order DEPTH-slot buffer that presents one instruction per cycle on the `fetch_de_*` bus under `decode_stall` backpressure. A ROB flush redirects the PC and silently discards every response still in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bit 0 ignored.
- `DEPTH`, default 4: buffer slots; power of two, at least 2.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `fetch_ic_req`  out  1  cache request valid
- `fetch_ic_addr`  out  30  word address, `pc[31:2]`
- `ic_fetch_ready`  in  1  cache accepts the request this cycle
- `ic_fetch_resp_valid`  in  1  response valid; responses return in order, at least 1 cycle after acceptance, with no backpressure
- `ic_fetch_resp_data`  in  32  instruction word
- `ic_fetch_resp_error`  in  1  access fault
- `fetch_bp_addr`  out  30  predictor lookup address, equal to `fetch_ic_addr`
- `bp_fetch_taken`  in  1  combinational prediction
- `bp_fetch_target`  in  30  predicted word target
- `bp_fetch_tag`  in  16  predictor tag
- `rob_flush`  in  1  redirect
- `rob_flush_pc`  in  31  redirect address `[31:1]`
- `fetch_de_valid`, `fetch_de_error`  out  1 each
- `fetch_de_addr`  out  31  PC `[31:1]`
- `fetch_de_insn`  out  32  instruction word
- `fetch_de_bptag`  out  16  predictor tag
- `fetch_de_bptaken`  out  1  predicted taken
- `decode_stall`  in  1  decode not accepting

## Operation
- State:
  - `pc[31:1]`
  - `halt`
  - slot array holding `{addr, insn, err, bptag, bptaken}`
  - pointers `tail` (allocate), `fill` (next response), `head` (output), each with a wrap bit
  - `drop_cnt`, range 0..DEPTH
- `occ = tail - head`; `pend = tail - fill`.
- Issue condition: `fetch_ic_req = ~rst & ~rob_flush & ~halt & ~pc[1] & (occ + drop_cnt < DEPTH)`.
- On issue (`fetch_ic_req & ic_fetch_ready`):
  - Allocate `slot[tail]` with `addr = pc`, `bptag`, `bptaken`; increment `tail`.
  - Next PC: `pc <= taken ? {target,1'b0} : pc + 4`.
- Response:
  - If `drop_cnt != 0`: decrement `drop_cnt` and discard the data.
  - Otherwise: write `insn`/`err` into `slot[fill]` and increment `fill`.
- Output: `fetch_de_*` is driven combinationally from `slot[head]`; `fetch_de_valid = (head != fill)`. A pop happens on `fetch_de_valid & ~decode_stall`.
- Misaligned PC (`pc[1]=1`, reachable only through a flush):
  - With no `drop_cnt` headroom required, allocate a slot that is filled immediately: `err=1`, `addr=pc`, `insn=0`, `bptaken=0`, `bptag=0`.
  - Advance both `tail` and `fill`, set `halt`, and send no cache request.
  - `decode` reports IALIGN from `addr[1]`.
  - Allocation still requires `occ < DEPTH`.
- Flush (highest priority; overrides issue/pop the same cycle):
  - `pc <= rob_flush_pc`; `head = fill = tail = 0`; `halt <= 0`.
  - `drop_cnt <= drop_cnt + pend - (resp_valid & drop_cnt==0 ? 1 : 0) - (resp_valid & drop_cnt!=0 ? 1 : 0)`, i.e. every response outstanding after this edge is dropped.
- A response error does not halt fetch; the ROB flush that follows the exception redirects.
- Invariant: `occ + drop_cnt <= DEPTH`, and outstanding cache requests never exceed DEPTH.

## Timing
- Reset values:
  - `pc = RESET_PC`; pointers, `drop_cnt` and `halt` all 0.
  - `fetch_de_valid = 0`; `fetch_ic_req = 0` during the reset cycle.
- First request is asserted the cycle after reset deasserts.
- Latency: a response at cycle N gives `fetch_de_valid` at N+1. There is no bypass.
- Throughput: 1 instruction/cycle when the cache returns 1 response/cycle and `decode_stall = 0`.
- Full buffer (`occ + drop_cnt == DEPTH`): `fetch_ic_req` is low; a pop in cycle N allows a request in cycle N+1.
- Empty buffer: outputs other than `fetch_de_valid` are don't-care.
- `rob_flush` cycle: no pop is counted and no request is issued; the new PC is requested the next cycle, subject to credits.
- Back-to-back flushes accumulate into `drop_cnt`.
- Pointers wrap modulo DEPTH, and the wrap bit distinguishes full from empty.

## Configuration
- `FETCH_BP_EN` defined:
  - The predictor is consulted.
  - Taken predictions redirect the next PC; tag/taken are recorded per slot.
- `FETCH_BP_EN` undefined:
  - `bp_*` inputs are ignored.
  - PC always advances `+4`; `fetch_de_bptaken = 0`, `fetch_de_bptag = 0`.
  - `fetch_bp_addr` is still driven.

## Test plan
- Reset sequence:
  - Stimulus: `RESET_PC = 0x100`, cache always ready, 1-cycle response, no stall.
  - Required response: requests 0x40, 0x41, 0x42 (word addresses); `fetch_de_addr` = 0x80, 0x82, 0x84 (`[31:1]`) on consecutive cycles, starting 2 cycles after the first request.
- Backpressure:
  - Stimulus: `decode_stall = 1` for 10 cycles.
  - Required response: exactly 4 requests issued, then `fetch_ic_req` low; on release, 4 instructions in order, then requests resume.
- Flush with drops:
  - Stimulus: 3 requests outstanding (3-cycle cache latency), then `rob_flush`, `rob_flush_pc = 0x200>>1`.
  - Required response: 3 stale responses discarded; the first output after the flush is `addr = 0x100` (`[31:1]`).
- Misaligned flush:
  - Stimulus: `rob_flush_pc = 0x102>>1`.
  - Required response: one output with `error = 1`, `addr[1] = 1`; no cache request until the next flush.
- Branch prediction (`FETCH_BP_EN`):
  - Stimulus: `bp_fetch_taken = 1`, target 0x80 at PC 0x100.
  - Required response: next request 0x80; output `bptaken = 1` with the recorded tag.
- Cache error:
  - Stimulus: `ic_fetch_resp_error = 1` on the 2nd response.
  - Required response: the 2nd output has `error = 1`, and fetching continues.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch stage: owns the fetch PC, issues I-cache word requests and buffers
// responses in order for decode. Define FETCH_BP_EN to let the branch predictor steer the PC.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_ic_req,
  output logic [29:0] fetch_ic_addr,
  input  logic        ic_fetch_ready,
  input  logic        ic_fetch_resp_valid,
  input  logic [31:0] ic_fetch_resp_data,
  input  logic        ic_fetch_resp_error,
  output logic [29:0] fetch_bp_addr,
  input  logic        bp_fetch_taken,
  input  logic [29:0] bp_fetch_target,
  input  logic [15:0] bp_fetch_tag,
  input  logic        rob_flush,
  input  logic [30:0] rob_flush_pc,
  output logic        fetch_de_valid,
  output logic        fetch_de_error,
  output logic [30:0] fetch_de_addr,
  output logic [31:0] fetch_de_insn,
  output logic [15:0] fetch_de_bptag,
  output logic        fetch_de_bptaken,
  input  logic        decode_stall
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0]   PtrOne = 1;
  localparam logic [PtrW+1:0] DepthW = (PtrW + 2)'(DEPTH);

  logic [31:1]   pc_q, pc_d;
  logic          halt_q, halt_d;
  logic [PtrW:0] tail_q, tail_d, fill_q, fill_d, head_q, head_d, drop_q, drop_d;

  logic [31:1] slot_addr_q  [DEPTH];
  logic [31:0] slot_insn_q  [DEPTH];
  logic        slot_err_q   [DEPTH];
  logic [15:0] slot_tag_q   [DEPTH];
  logic        slot_taken_q [DEPTH];

  logic [PtrW:0]   occ, pend;
  logic [PtrW+1:0] credit_use;
  logic [PtrW-1:0] tail_idx, fill_idx, head_idx;
  logic            issue, misalign_alloc, resp_fill, pop;
  logic            bp_taken;
  logic [29:0]     bp_target;
  logic [15:0]     bp_tag;

`ifdef FETCH_BP_EN
  assign bp_taken  = bp_fetch_taken;
  assign bp_target = bp_fetch_target;
  assign bp_tag    = bp_fetch_tag;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_fetch_taken, bp_fetch_target, bp_fetch_tag};
  assign bp_taken  = 1'b0;
  assign bp_target = '0;
  assign bp_tag    = '0;
`endif

  assign occ        = tail_q - head_q;
  assign pend       = tail_q - fill_q;
  assign credit_use = {1'b0, occ} + {1'b0, drop_q};
  assign tail_idx   = tail_q[PtrW-1:0];
  assign fill_idx   = fill_q[PtrW-1:0];
  assign head_idx   = head_q[PtrW-1:0];

  // Slots still owed to dropped responses count against credit, so in-flight requests stay bounded.
  assign fetch_ic_req   = ~rst & ~rob_flush & ~halt_q & ~pc_q[1] & (credit_use < DepthW);
  assign fetch_ic_addr  = pc_q[31:2];
  assign fetch_bp_addr  = pc_q[31:2];
  assign issue          = fetch_ic_req & ic_fetch_ready;
  assign misalign_alloc = ~rst & ~rob_flush & ~halt_q & pc_q[1] & ({1'b0, occ} < DepthW);
  assign resp_fill      = ic_fetch_resp_valid & (drop_q == '0);
  assign fetch_de_valid = ~rst & (head_q != fill_q);
  assign pop            = fetch_de_valid & ~decode_stall & ~rob_flush;

  always_comb begin
    pc_d   = pc_q;
    halt_d = halt_q;
    tail_d = tail_q;
    fill_d = fill_q;
    head_d = head_q;
    drop_d = drop_q;
    if (rob_flush) begin
      pc_d   = rob_flush_pc;
      halt_d = 1'b0;
      tail_d = '0;
      fill_d = '0;
      head_d = '0;
      // Every response still owed after this edge is stale.
      drop_d = drop_q + pend - {{PtrW{1'b0}}, ic_fetch_resp_valid};
    end else begin
      if (issue) begin
        tail_d = tail_q + PtrOne;
        pc_d   = bp_taken ? {bp_target, 1'b0} : pc_q + 31'd2;
      end
      if (misalign_alloc) begin
        tail_d = tail_q + PtrOne;
        halt_d = 1'b1;
      end
      if (misalign_alloc || resp_fill) begin
        fill_d = fill_q + PtrOne;
      end
      if (ic_fetch_resp_valid && !resp_fill) begin
        drop_d = drop_q - PtrOne;
      end
      if (pop) begin
        head_d = head_q + PtrOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC[31:1];
      halt_q <= 1'b0;
      tail_q <= '0;
      fill_q <= '0;
      head_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
      head_q <= head_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      slot_addr_q[tail_idx]  <= pc_q;
      slot_tag_q[tail_idx]   <= bp_tag;
      slot_taken_q[tail_idx] <= bp_taken;
    end else if (misalign_alloc) begin
      slot_addr_q[tail_idx]  <= pc_q;
      slot_insn_q[tail_idx]  <= '0;
      slot_err_q[tail_idx]   <= 1'b1;
      slot_tag_q[tail_idx]   <= '0;
      slot_taken_q[tail_idx] <= 1'b0;
    end
    if (resp_fill) begin
      slot_insn_q[fill_idx] <= ic_fetch_resp_data;
      slot_err_q[fill_idx]  <= ic_fetch_resp_error;
    end
  end

  assign fetch_de_addr    = slot_addr_q[head_idx];
  assign fetch_de_insn    = slot_insn_q[head_idx];
  assign fetch_de_error   = slot_err_q[head_idx];
  assign fetch_de_bptag   = slot_tag_q[head_idx];
  assign fetch_de_bptaken = slot_taken_q[head_idx];

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: queue-based reference model plus a scripted cache, directed phases then random.
module tb_fetch;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ic_req;
  logic [29:0] fetch_ic_addr;
  logic        ic_fetch_ready;
  logic        ic_fetch_resp_valid;
  logic [31:0] ic_fetch_resp_data;
  logic        ic_fetch_resp_error;
  logic [29:0] fetch_bp_addr;
  logic        bp_fetch_taken;
  logic [29:0] bp_fetch_target;
  logic [15:0] bp_fetch_tag;
  logic        rob_flush;
  logic [30:0] rob_flush_pc;
  logic        fetch_de_valid;
  logic        fetch_de_error;
  logic [30:0] fetch_de_addr;
  logic [31:0] fetch_de_insn;
  logic [15:0] fetch_de_bptag;
  logic        fetch_de_bptaken;
  logic        decode_stall;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fetch_ic_req        (fetch_ic_req),
    .fetch_ic_addr       (fetch_ic_addr),
    .ic_fetch_ready      (ic_fetch_ready),
    .ic_fetch_resp_valid (ic_fetch_resp_valid),
    .ic_fetch_resp_data  (ic_fetch_resp_data),
    .ic_fetch_resp_error (ic_fetch_resp_error),
    .fetch_bp_addr       (fetch_bp_addr),
    .bp_fetch_taken      (bp_fetch_taken),
    .bp_fetch_target     (bp_fetch_target),
    .bp_fetch_tag        (bp_fetch_tag),
    .rob_flush           (rob_flush),
    .rob_flush_pc        (rob_flush_pc),
    .fetch_de_valid      (fetch_de_valid),
    .fetch_de_error      (fetch_de_error),
    .fetch_de_addr       (fetch_de_addr),
    .fetch_de_insn       (fetch_de_insn),
    .fetch_de_bptag      (fetch_de_bptag),
    .fetch_de_bptaken    (fetch_de_bptaken),
    .decode_stall        (decode_stall)
  );

  typedef struct {
    logic [30:0] addr;
    logic [31:0] insn;
    logic        err;
    logic [15:0] tag;
    logic        taken;
    bit          filled;
  } ent_t;

  typedef struct {
    logic [29:0] addr;
    int          due;
    logic        err;
  } creq_t;

  typedef struct {
    logic [30:0] addr;
    logic        err;
    logic [15:0] tag;
    logic        taken;
  } out_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: byte PC, list of buffered instructions in program order, drop count.
  logic [31:0] m_pc;
  bit          m_halt;
  int          m_drop;
  ent_t        mq[$];

  // Cache stimulus and observation logs.
  creq_t       cq[$];
  int          last_due, req_idx;
  int          ready_pct, lat_min, lat_max, stall_pct, err_pct, bp_mode, err_idx;
  bit          force_err;
  logic [29:0] obs_req[$];
  out_t        obs_out[$];
  int          first_req_cyc, first_out_cyc, rel_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: dut=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] insn_of(input logic [29:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [29:0] req_at(input int i);
    if (i < obs_req.size()) return obs_req[i];
    return '1;
  endfunction

  function automatic out_t out_at(input int i);
    out_t o;
    o.addr = '1; o.err = 1'b1; o.tag = '1; o.taken = 1'b1;
    if (i < obs_out.size()) o = obs_out[i];
    return o;
  endfunction

  task automatic clear_logs();
    obs_req.delete();
    obs_out.delete();
    first_req_cyc = -1;
    first_out_cyc = -1;
  endtask

  // One clock cycle: drive stimulus, compare against the model mid-cycle, advance the model.
  task automatic tick();
    bit          exp_req, exp_valid, do_pop, do_mis, found, e_taken;
    logic [15:0] e_tag;
    int          pend, lat, due;
    ent_t        e;
    creq_t       c;
    out_t        o;

    ic_fetch_ready = ($urandom_range(99) < ready_pct);
    decode_stall   = ($urandom_range(99) < stall_pct);
    if (cq.size() > 0 && cq[0].due == cyc) begin
      ic_fetch_resp_valid = 1'b1;
      ic_fetch_resp_data  = insn_of(cq[0].addr);
      ic_fetch_resp_error = cq[0].err;
    end else begin
      ic_fetch_resp_valid = 1'b0;
      ic_fetch_resp_data  = $urandom;
      ic_fetch_resp_error = 1'($urandom);
    end
    bp_fetch_target = 30'($urandom);
    bp_fetch_tag    = 16'($urandom);
    case (bp_mode)
      1: bp_fetch_taken = ($urandom_range(3) == 0);
      2: begin
        bp_fetch_taken  = (m_pc == 32'h100);
        bp_fetch_target = 30'h80;
        bp_fetch_tag    = 16'hbeef;
      end
      default: bp_fetch_taken = 1'b0;
    endcase
`ifdef FETCH_BP_EN
    e_taken = bp_fetch_taken;
    e_tag   = bp_fetch_tag;
`else
    e_taken = 1'b0;
    e_tag   = 16'h0;
`endif

    pend = 0;
    foreach (mq[i]) if (!mq[i].filled) pend++;
    exp_req   = !rob_flush && !m_halt && (m_pc[1] == 1'b0) && (mq.size() + m_drop < DEPTH);
    exp_valid = (mq.size() > 0) && mq[0].filled;

    @(negedge clk);
    chk("ic_req", fetch_ic_req, exp_req);
    if (exp_req) begin
      chk("ic_addr", fetch_ic_addr, m_pc >> 2);
      chk("bp_addr", fetch_bp_addr, m_pc >> 2);
    end
    chk("de_valid", fetch_de_valid, exp_valid);
    if (exp_valid) begin
      chk("de_addr", fetch_de_addr, mq[0].addr);
      chk("de_insn", fetch_de_insn, mq[0].insn);
      chk("de_error", fetch_de_error, mq[0].err);
      chk("de_bptag", fetch_de_bptag, mq[0].tag);
      chk("de_bptaken", fetch_de_bptaken, mq[0].taken);
    end

    if (fetch_ic_req && ic_fetch_ready) begin
      obs_req.push_back(fetch_ic_addr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (fetch_de_valid && !decode_stall && !rob_flush) begin
      o.addr = fetch_de_addr; o.err = fetch_de_error;
      o.tag = fetch_de_bptag; o.taken = fetch_de_bptaken;
      obs_out.push_back(o);
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end

    if (rob_flush) begin
      m_drop = m_drop + pend - (ic_fetch_resp_valid ? 1 : 0);
      mq.delete();
      m_pc   = {rob_flush_pc, 1'b0};
      m_halt = 1'b0;
    end else begin
      do_pop = exp_valid && !decode_stall;
      do_mis = !m_halt && (m_pc[1] == 1'b1) && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (ic_fetch_resp_valid) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          found = 1'b0;
          foreach (mq[i]) begin
            if (!found && !mq[i].filled) begin
              mq[i].insn = ic_fetch_resp_data;
              mq[i].err = ic_fetch_resp_error;
              mq[i].filled = 1'b1;
              found = 1'b1;
            end
          end
        end
      end
      if (exp_req && ic_fetch_ready) begin
        e.addr = m_pc[31:1]; e.insn = '0; e.err = 1'b0;
        e.tag = e_tag; e.taken = e_taken; e.filled = 1'b0;
        mq.push_back(e);
        m_pc = e_taken ? {bp_fetch_target, 2'b00} : m_pc + 32'd4;
      end
      if (do_mis) begin
        e.addr = m_pc[31:1]; e.insn = '0; e.err = 1'b1;
        e.tag = '0; e.taken = 1'b0; e.filled = 1'b1;
        mq.push_back(e);
        m_halt = 1'b1;
      end
    end

    // The cache answers every accepted request regardless of flushes.
    if (ic_fetch_resp_valid) void'(cq.pop_front());
    if (exp_req && ic_fetch_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      c.addr = fetch_ic_addr;
      c.addr = e.addr[31:2];
      c.due  = due;
      c.err  = force_err ? (req_idx == err_idx) : ($urandom_range(99) < err_pct);
      req_idx++;
      cq.push_back(c);
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rob_flush = 1'b0;
    rob_flush_pc = '0;
    ic_fetch_ready = 1'b1;
    ic_fetch_resp_valid = 1'b0;
    decode_stall = 1'b0;
    bp_fetch_taken = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ic_req", fetch_ic_req, 1'b0);
      chk("rst_de_valid", fetch_de_valid, 1'b0);
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b0;
    m_pc = RESET_PC & ~32'h1;
    m_halt = 1'b0;
    m_drop = 0;
    mq.delete();
    cq.delete();
    last_due = cyc;
    req_idx = 0;
    rel_cyc = cyc;
    force_err = 1'b0;
    err_pct = 0;
    bp_mode = 0;
    ready_pct = 100;
    stall_pct = 0;
    lat_min = 1;
    lat_max = 1;
    clear_logs();
  endtask

  initial begin
    int bad;
    logic [30:0] fpc;
    rst = 1'b1;
    rob_flush = 1'b0;
    rob_flush_pc = '0;
    ic_fetch_ready = 1'b0;
    ic_fetch_resp_valid = 1'b0;
    ic_fetch_resp_data = '0;
    ic_fetch_resp_error = 1'b0;
    bp_fetch_taken = 1'b0;
    bp_fetch_target = '0;
    bp_fetch_tag = '0;
    decode_stall = 1'b0;
    @(posedge clk);
    #1;

    // Reset sequence
    do_reset();
    repeat (8) tick();
    chk("p1_nreq", obs_req.size() >= 3, 1'b1);
    chk("p1_req0", req_at(0), 30'h40);
    chk("p1_req1", req_at(1), 30'h41);
    chk("p1_req2", req_at(2), 30'h42);
    chk("p1_nout", obs_out.size() >= 3, 1'b1);
    chk("p1_out0", out_at(0).addr, 31'h80);
    chk("p1_out1", out_at(1).addr, 31'h82);
    chk("p1_out2", out_at(2).addr, 31'h84);
    chk("p1_first_req_cyc", first_req_cyc, rel_cyc);
    chk("p1_first_out_cyc", first_out_cyc, first_req_cyc + 2);

    // Backpressure
    do_reset();
    stall_pct = 100;
    repeat (10) tick();
    chk("p2_req_while_stalled", obs_req.size(), 4);
    chk("p2_req_low_full", fetch_ic_req, 1'b0);
    clear_logs();
    stall_pct = 0;
    repeat (8) tick();
    chk("p2_out0", out_at(0).addr, 31'h80);
    chk("p2_out1", out_at(1).addr, 31'h82);
    chk("p2_out2", out_at(2).addr, 31'h84);
    chk("p2_out3", out_at(3).addr, 31'h86);
    chk("p2_resume_addr", req_at(0), 30'h44);
    chk("p2_resume_cyc", first_req_cyc, first_out_cyc + 1);

    // Flush with drops
    do_reset();
    lat_min = 3;
    lat_max = 3;
    repeat (3) tick();
    chk("p3_req_pre", obs_req.size(), 3);
    chk("p3_out_pre", obs_out.size(), 0);
    clear_logs();
    rob_flush = 1'b1;
    rob_flush_pc = 31'h100;
    tick();
    rob_flush = 1'b0;
    chk("p3_model_drop", m_drop, 2);
    repeat (14) tick();
    chk("p3_first_req", req_at(0), 30'h80);
    chk("p3_first_out", out_at(0).addr, 31'h100);
    bad = 0;
    foreach (obs_out[i]) if (obs_out[i].addr < 31'h100) bad++;
    chk("p3_stale_out", bad, 0);

    // Misaligned flush
    do_reset();
    lat_max = 2;
    repeat (4) tick();
    clear_logs();
    rob_flush = 1'b1;
    rob_flush_pc = 31'h81;
    tick();
    rob_flush = 1'b0;
    repeat (12) tick();
    chk("p4_nout", obs_out.size(), 1);
    chk("p4_err", out_at(0).err, 1'b1);
    chk("p4_addr", out_at(0).addr, 31'h81);
    chk("p4_no_req", obs_req.size(), 0);
    clear_logs();
    rob_flush = 1'b1;
    rob_flush_pc = 31'h80;
    tick();
    rob_flush = 1'b0;
    repeat (6) tick();
    chk("p4_resume", req_at(0), 30'h40);

    // Cache error on the second response
    do_reset();
    force_err = 1'b1;
    err_idx = 1;
    repeat (10) tick();
    force_err = 1'b0;
    chk("p5_nout", obs_out.size() >= 5, 1'b1);
    chk("p5_err0", out_at(0).err, 1'b0);
    chk("p5_err1", out_at(1).err, 1'b1);
    chk("p5_addr1", out_at(1).addr, 31'h82);
    chk("p5_err2", out_at(2).err, 1'b0);

    // Predictor taken at PC 0x100 toward word 0x80
    do_reset();
    bp_mode = 2;
    repeat (6) tick();
    chk("p6_req0", req_at(0), 30'h40);
`ifdef FETCH_BP_EN
    chk("p6_req1", req_at(1), 30'h80);
    chk("p6_taken0", out_at(0).taken, 1'b1);
    chk("p6_tag0", out_at(0).tag, 16'hbeef);
    chk("p6_addr1", out_at(1).addr, 31'h100);
    chk("p6_taken1", out_at(1).taken, 1'b0);
`else
    chk("p6_req1", req_at(1), 30'h41);
    chk("p6_taken0", out_at(0).taken, 1'b0);
    chk("p6_tag0", out_at(0).tag, 16'h0);
`endif

    // Random traffic
    do_reset();
    ready_pct = 70;
    lat_min = 1;
    lat_max = 4;
    err_pct = 10;
    bp_mode = 1;
    for (int seg = 0; seg < 8; seg++) begin
      stall_pct = (seg % 2 == 1) ? 80 : 10;
      repeat (500) begin
        rob_flush = ($urandom_range(99) < 3);
        fpc = 31'($urandom);
        fpc[0] = ($urandom_range(4) == 0);
        rob_flush_pc = fpc;
        tick();
      end
    end
    rob_flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
